// File: rtl/video_timing_generator.sv
// video_timing_generator
//   Raster timing generator producing pixel/line counters, sync pulses and
//   frame markers. It decodes them from a shadow copy of the timing inputs.
//   The shadow copy reloads on reset and at every frame wrap. While the loaded
//   set is invalid, it also reloads on every enabled cycle.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   enable       pixel tick; all state advances only when high
//   HActive..HBack  horizontal segment lengths (pixels), XWIDTH bits
//   VActive..VBack  vertical segment lengths (lines), YWIDTH bits
//   hsync, vsync    sync pulses at HSYNC_POL / VSYNC_POL active level
//   xposition, yposition  current pixel / line counters
//   ActiveVideo  inside the active region
//   LineEnd      last pixel of the line
//   FrameEnd     last pixel of the frame
//   ConfigError  loaded timing set is invalid
module video_timing_generator #(
    parameter int XWIDTH    = 10,
    parameter int YWIDTH    = 10,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [XWIDTH-1:0] HActive,
    input  logic [XWIDTH-1:0] HFront,
    input  logic [XWIDTH-1:0] HSync,
    input  logic [XWIDTH-1:0] HBack,
    input  logic [YWIDTH-1:0] VActive,
    input  logic [YWIDTH-1:0] VFront,
    input  logic [YWIDTH-1:0] VSync,
    input  logic [YWIDTH-1:0] VBack,
    output logic              hsync,
    output logic              vsync,
    output logic [XWIDTH-1:0] xposition,
    output logic [YWIDTH-1:0] yposition,
    output logic              ActiveVideo,
    output logic              LineEnd,
    output logic              FrameEnd,
    output logic              ConfigError
);

    // Sums of four segments can need two extra bits, so totals carry them.
    localparam int XT = XWIDTH + 2;
    localparam int YT = YWIDTH + 2;

    localparam logic [XT-1:0] H_LIMIT = {{(XT-1){1'b0}}, 1'b1} << XWIDTH;
    localparam logic [YT-1:0] V_LIMIT = {{(YT-1){1'b0}}, 1'b1} << YWIDTH;

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    function automatic logic timing_ok(
        input logic [XWIDTH-1:0] ha, hf, hs, hb,
        input logic [YWIDTH-1:0] va, vf, vs, vb
    );
        logic [XT-1:0] ht;
        logic [YT-1:0] vt;
        ht = {2'b00, ha} + {2'b00, hf} + {2'b00, hs} + {2'b00, hb};
        vt = {2'b00, va} + {2'b00, vf} + {2'b00, vs} + {2'b00, vb};
        return (ha != '0) && (hs != '0) && (va != '0) && (vs != '0) &&
               (ht <= H_LIMIT) && (vt <= V_LIMIT);
    endfunction

    // Shadow timing set
    logic [XWIDTH-1:0] sh_ha, sh_hf, sh_hs, sh_hb;
    logic [YWIDTH-1:0] sh_va, sh_vf, sh_vs, sh_vb;

    logic [XT-1:0] h_sync_start, h_sync_end, h_total;
    logic [YT-1:0] v_sync_start, v_sync_end, v_total;

    assign h_sync_start = {2'b00, sh_ha} + {2'b00, sh_hf};
    assign h_sync_end   = h_sync_start + {2'b00, sh_hs};
    assign h_total      = h_sync_end + {2'b00, sh_hb};
    assign v_sync_start = {2'b00, sh_va} + {2'b00, sh_vf};
    assign v_sync_end   = v_sync_start + {2'b00, sh_vs};
    assign v_total      = v_sync_end + {2'b00, sh_vb};

    logic in_ok;
    logic reload;

    assign in_ok = timing_ok(HActive, HFront, HSync, HBack,
                             VActive, VFront, VSync, VBack);

    // A frame wrap and an invalid set both restart from 0,0 with freshly
    // captured inputs, so they share the reset path.
    assign reload = !reset || (enable && (ConfigError || FrameEnd));

    // Outputs are registered from the decode of the *next* counter values so
    // every flag lines up with the position it describes.
    logic [XWIDTH-1:0] x_next;
    logic [YWIDTH-1:0] y_next;
    logic [XT-1:0]     x_ext;
    logic [YT-1:0]     y_ext;
    logic              act_n, hs_n, vs_n, le_n, fe_n;

    always_comb begin
        x_next = LineEnd ? '0 : xposition + 1'b1;
        y_next = LineEnd ? yposition + 1'b1 : yposition;
        x_ext  = {2'b00, x_next};
        y_ext  = {2'b00, y_next};
        act_n  = (x_next < sh_ha) && (y_next < sh_va);
        hs_n   = (x_ext >= h_sync_start) && (x_ext < h_sync_end);
        vs_n   = (y_ext >= v_sync_start) && (y_ext < v_sync_end);
        le_n   = (x_ext == h_total - 1'b1);
        fe_n   = le_n && (y_ext == v_total - 1'b1);
    end

    always_ff @(posedge clock) begin
        if (reload) begin
            sh_ha <= HActive;
            sh_hf <= HFront;
            sh_hs <= HSync;
            sh_hb <= HBack;
            sh_va <= VActive;
            sh_vf <= VFront;
            sh_vs <= VSync;
            sh_vb <= VBack;
            xposition   <= '0;
            yposition   <= '0;
            LineEnd     <= 1'b0;
            FrameEnd    <= 1'b0;
            // Position 0,0 of a valid set is always active video and never
            // inside a sync (HActive, VActive >= 1), and never a line end
            // (HTotal >= 2).
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            ActiveVideo <= in_ok;
            ConfigError <= ~in_ok;
        end else if (enable) begin
            xposition   <= x_next;
            yposition   <= y_next;
            LineEnd     <= le_n;
            FrameEnd    <= fe_n;
            hsync       <= hs_n ? HS_ON : ~HS_ON;
            vsync       <= vs_n ? VS_ON : ~VS_ON;
            ActiveVideo <= act_n;
        end
    end

endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator
//   Directed bench for video_timing_generator: a 10-bit instance exercises
//   base timing, enable gating, mid-frame parameter changes, invalid sets and
//   mid-frame reset; a 3-bit instance exercises width boundaries and the
//   minimal 2x2 frame.
module tb_video_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 10-bit instance
    logic       reset, enable;
    logic [9:0] ha, hf, hs, hb, va, vf, vs, vb;
    logic       hsync, vsync, av, le, fe, ce;
    logic [9:0] xp, yp;

    video_timing_generator #(.XWIDTH(10), .YWIDTH(10), .HSYNC_POL(0), .VSYNC_POL(0)) dut (
        .clock(clk), .reset(reset), .enable(enable),
        .HActive(ha), .HFront(hf), .HSync(hs), .HBack(hb),
        .VActive(va), .VFront(vf), .VSync(vs), .VBack(vb),
        .hsync(hsync), .vsync(vsync), .xposition(xp), .yposition(yp),
        .ActiveVideo(av), .LineEnd(le), .FrameEnd(fe), .ConfigError(ce)
    );

    // 3-bit instance
    logic       reset2, enable2;
    logic [2:0] ha2, hf2, hs2, hb2, va2, vf2, vs2, vb2;
    logic       hsync2, vsync2, av2, le2, fe2, ce2;
    logic [2:0] xp2, yp2;

    video_timing_generator #(.XWIDTH(3), .YWIDTH(3), .HSYNC_POL(0), .VSYNC_POL(0)) dut2 (
        .clock(clk), .reset(reset2), .enable(enable2),
        .HActive(ha2), .HFront(hf2), .HSync(hs2), .HBack(hb2),
        .VActive(va2), .VFront(vf2), .VSync(vs2), .VBack(vb2),
        .hsync(hsync2), .vsync(vsync2), .xposition(xp2), .yposition(yp2),
        .ActiveVideo(av2), .LineEnd(le2), .FrameEnd(fe2), .ConfigError(ce2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Syncs are active-low on both instances.
    task automatic chk_main(input string tag, input int ex, input int ey, input bit hs_on,
                            input bit vs_on, input bit e_av, input bit e_le, input bit e_fe,
                            input bit e_ce);
        chk({tag, ".x"},     32'(xp),     32'(ex));
        chk({tag, ".y"},     32'(yp),     32'(ey));
        chk({tag, ".hsync"}, 32'(hsync),  32'(!hs_on));
        chk({tag, ".vsync"}, 32'(vsync),  32'(!vs_on));
        chk({tag, ".av"},    32'(av),     32'(e_av));
        chk({tag, ".le"},    32'(le),     32'(e_le));
        chk({tag, ".fe"},    32'(fe),     32'(e_fe));
        chk({tag, ".ce"},    32'(ce),     32'(e_ce));
    endtask

    task automatic chk2(input string tag, input int ex, input int ey, input bit hs_on,
                        input bit vs_on, input bit e_av, input bit e_le, input bit e_fe,
                        input bit e_ce);
        chk({tag, ".x"},     32'(xp2),    32'(ex));
        chk({tag, ".y"},     32'(yp2),    32'(ey));
        chk({tag, ".hsync"}, 32'(hsync2), 32'(!hs_on));
        chk({tag, ".vsync"}, 32'(vsync2), 32'(!vs_on));
        chk({tag, ".av"},    32'(av2),    32'(e_av));
        chk({tag, ".le"},    32'(le2),    32'(e_le));
        chk({tag, ".fe"},    32'(fe2),    32'(e_fe));
        chk({tag, ".ce"},    32'(ce2),    32'(e_ce));
    endtask

    // Base timing H=4/1/2/1 V=3/1/1/1: 8x6 frame, idx = cycle within frame.
    task automatic chk_base(input string tag, input int idx);
        int x, y;
        x = idx % 8;
        y = idx / 8;
        chk_main(tag, x, y, (x == 5 || x == 6), (y == 4), (x < 4 && y < 3),
                 (x == 7), (x == 7 && y == 5), 1'b0);
    endtask

    // Wide timing H=6/1/2/1 V=3/1/1/1: 10x6 frame.
    task automatic chk_wide(input string tag, input int idx);
        int x, y;
        x = idx % 10;
        y = idx / 10;
        chk_main(tag, x, y, (x == 7 || x == 8), (y == 4), (x < 6 && y < 3),
                 (x == 9), (x == 9 && y == 5), 1'b0);
    endtask

    initial begin
        ha = 10'd4; hf = 10'd1; hs = 10'd2; hb = 10'd1;
        va = 10'd3; vf = 10'd1; vs = 10'd1; vb = 10'd1;
        ha2 = 3'd4; hf2 = 3'd1; hs2 = 3'd2; hb2 = 3'd1;
        va2 = 3'd3; vf2 = 3'd1; vs2 = 3'd1; vb2 = 3'd1;
        reset = 1'b0; enable = 1'b1;
        reset2 = 1'b0; enable2 = 1'b1;

        // Reset state
        tick();
        chk_base("reset", 0);
        reset = 1'b1;

        // One full frame plus return to origin: period 48
        for (int k = 1; k <= 48; k++) begin
            tick();
            chk_base("base", k % 48);
        end

        // Enable toggling: 48 enabled ticks over 96 clocks
        for (int c = 0; c < 96; c++) begin
            enable = (c % 2 == 0);
            tick();
            chk_base("toggle", (c / 2 + 1) % 48);
        end
        enable = 1'b1;

        // HActive change at y=1 takes effect only after the frame wrap
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_base("pre_chg", k);
        end
        ha = 10'd6;
        for (int k = 9; k <= 47; k++) begin
            tick();
            chk_base("old_frame", k);
        end
        for (int j = 0; j < 60; j++) begin
            tick();
            chk_wide("new_frame", j);
        end

        // Invalid set (HSync=0) loaded at the wrap
        ha = 10'd4; hs = 10'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_main("cfg_bad", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        hs = 10'd2;
        tick();
        chk_base("cfg_fix", 0);
        tick();
        chk_base("cfg_run", 1);

        // Mid-frame reset at x=5,y=2
        for (int k = 2; k <= 21; k++) begin
            tick();
            chk_base("pre_rst", k);
        end
        reset = 1'b0;
        tick();
        chk_base("rst_mid", 0);
        reset = 1'b1;

        // Reset wins over enable=0
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_base("pre_rst2", k);
        end
        enable = 1'b0; reset = 1'b0;
        tick();
        chk_base("rst_noen", 0);
        enable = 1'b1; reset = 1'b1;

        // 3-bit instance: HTotal 8 = 2^3 is valid and wraps 7->0
        chk2("w3_rst", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset2 = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        chk2("w3_x7", 7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("w3_wrap", 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // HTotal 9 exceeds 3-bit range
        hb2 = 3'd2; reset2 = 1'b0;
        tick();
        chk2("w3_ovf", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Minimal 2x2 frame with zero-length porches
        ha2 = 3'd1; hf2 = 3'd0; hs2 = 3'd1; hb2 = 3'd0;
        va2 = 3'd1; vf2 = 3'd0; vs2 = 3'd1; vb2 = 3'd0;
        tick();
        chk2("min_rst", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset2 = 1'b1;
        tick();
        chk2("min_a", 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("min_b", 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk2("min_c", 1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk2("min_d", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
